// File: rtl/fseq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fseq_pkg
// Description : Shared definitions for the fetch sequencer: FSM state
//               encodings and the default instruction/PC widths.
// Revision    : 1.0 - initial release
// ============================================================================
package fseq_pkg;

  // Default widths used by fetch_sequencer and fseq_pc
  localparam int IW_DEFAULT = 32;
  localparam int PW_DEFAULT = 16;

  // FSM state encodings; values 5..7 are unused and recover to S_FETCH
  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_WAIT    = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALT    = 3'd4
  } state_e;

endpackage : fseq_pkg
`default_nettype wire

// File: rtl/fseq_pc.sv
`default_nettype none
// ============================================================================
// Module      : fseq_pc
// Description : Program counter register with load / increment / hold.
//               Resets asynchronously to RESET_PC. Increment wraps modulo
//               2^PW with no overflow indication.
// Ports       : clk      - rising-edge clock
//               rst_n    - asynchronous active-low reset
//               load_i   - load target_i (takes priority over inc_i)
//               inc_i    - increment PC by one
//               target_i - value loaded when load_i is high
//               pc_o     - current program counter
// Revision    : 1.0 - initial release
// ============================================================================
module fseq_pc
  import fseq_pkg::*;
#(
  parameter int            PW       = PW_DEFAULT,
  parameter logic [PW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          inc_i,
  input  logic [PW-1:0] target_i,
  output logic [PW-1:0] pc_o
);

  localparam logic [PW-1:0] c_one = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0] pc_q;
  logic [PW-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i;
    end else if (inc_i) begin
      // Natural PW-bit overflow provides the all-ones -> zero wrap
      pc_d = pc_q + c_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule : fseq_pc
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction fetch sequencer. Walks FETCH -> WAIT -> DECODE ->
//               EXECUTE for every instruction (4 cycles minimum), with
//               memory wait, downstream stall, branch and halt/resume.
// Ports       : clk             - rising-edge clock
//               reset           - asynchronous active-low reset
//               mem_rdata       - instruction read from RAM (sampled in WAIT)
//               mem_valid       - mem_rdata valid this cycle
//               stall           - downstream not ready
//               branch_taken    - load branch_target instead of incrementing
//               branch_target   - next PC when branch_taken
//               halt_req        - enter HALT after the current instruction
//               resume          - leave HALT
//               mem_req         - read request to RAM at PC_out
//               PC_out          - program counter
//               instruction_out - latched instruction
//               instr_valid     - high exactly in EXECUTE
//               current_state   - FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fseq_pkg::*;
#(
  parameter int            IW       = IW_DEFAULT,
  parameter int            PW       = PW_DEFAULT,
  parameter logic [PW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] mem_rdata,
  input  logic          mem_valid,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [PW-1:0] branch_target,
  input  logic          halt_req,
  input  logic          resume,
  output logic          mem_req,
  output logic [PW-1:0] PC_out,
  output logic [IW-1:0] instruction_out,
  output logic          instr_valid,
  output logic [2:0]    current_state
);

  state_e        state_q;
  state_e        state_d;
  logic [IW-1:0] instr_q;
  logic [IW-1:0] instr_d;
  logic          pc_load;
  logic          pc_inc;

  // --------------------------------------------------------------------------
  // Next-state, instruction capture and PC control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;

    case (state_q)
      S_FETCH: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (mem_valid) begin
          instr_d = mem_rdata;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (!stall) begin
          state_d = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        // The PC advances on the edge that leaves EXECUTE, whichever
        // state comes next
        if (!stall) begin
          pc_load = branch_taken;
          pc_inc  = !branch_taken;
          state_d = halt_req ? S_HALT : S_FETCH;
        end
      end

      S_HALT: begin
        if (resume) begin
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and instruction registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Program counter
  // --------------------------------------------------------------------------
  fseq_pc #(
    .PW       (PW),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (reset),
    .load_i   (pc_load),
    .inc_i    (pc_inc),
    .target_i (branch_target),
    .pc_o     (PC_out)
  );

  // --------------------------------------------------------------------------
  // Outputs decoded from registered state only
  // --------------------------------------------------------------------------
  assign mem_req         = (state_q == S_FETCH) || (state_q == S_WAIT);
  assign instr_valid     = (state_q == S_EXECUTE);
  assign current_state   = state_q;
  assign instruction_out = instr_q;

endmodule : fetch_sequencer
`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Parameters
REQ-001 The module SHALL have parameter IW, default 32, meaning instruction width in bits.
REQ-002 The module SHALL have parameter PW, default 16, meaning program counter width in bits.
REQ-003 The module SHALL have parameter RESET_PC, default 0, meaning the PC value loaded on reset.

Interface
REQ-004 The module SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port mem_rdata, input, IW bits: instruction read from RAM.
REQ-007 The module SHALL have port mem_valid, input, 1 bit: mem_rdata valid this cycle.
REQ-008 The module SHALL have port stall, input, 1 bit: downstream (MAB/RBT/ALU) not ready.
REQ-009 The module SHALL have port branch_taken, input, 1 bit: load branch_target instead of incrementing.
REQ-010 The module SHALL have port branch_target, input, PW bits: next PC when branch_taken.
REQ-011 The module SHALL have port halt_req, input, 1 bit: enter HALT after current instruction.
REQ-012 The module SHALL have port resume, input, 1 bit: leave HALT.
REQ-013 The module SHALL have port mem_req, output, 1 bit: read request to RAM at PC_out.
REQ-014 The module SHALL have port PC_out, output, PW bits: program counter to MAB.
REQ-015 The module SHALL have port instruction_out, output, IW bits: latched instruction for MAB/RBT/ALU.
REQ-016 The module SHALL have port instr_valid, output, 1 bit: high exactly in EXECUTE.
REQ-017 The module SHALL have port current_state, output, 3 bits: state encoding.

Function
REQ-018 The FSM SHALL have states FETCH=0, WAIT=1, DECODE=2, EXECUTE=3, HALT=4; encodings 5-7 SHALL go to FETCH on the next edge.
REQ-019 FETCH SHALL assert mem_req and go to WAIT unconditionally.
REQ-020 WAIT SHALL hold mem_req high; on mem_valid it SHALL register mem_rdata into instruction_out and go to DECODE, otherwise it SHALL stay in WAIT.
REQ-021 DECODE SHALL go to EXECUTE when stall=0 and SHALL hold while stall=1.
REQ-022 EXECUTE SHALL hold (no PC update) while stall=1; when stall=0 it SHALL update PC and leave.
REQ-023 The PC update SHALL be PC_out <= branch_taken ? branch_target : PC_out+1, modulo 2^PW (all-ones wraps to 0, no flag).
REQ-024 On leaving EXECUTE, the next state SHALL be HALT if halt_req=1, else FETCH; the PC update SHALL occur in both cases.
REQ-025 HALT SHALL go to FETCH on resume=1; PC_out and instruction_out SHALL hold.
REQ-026 instruction_out SHALL change only on the WAIT-to-DECODE edge.
REQ-027 Minimum latency SHALL be 4 cycles per instruction (FETCH, WAIT with mem_valid, DECODE, EXECUTE).
REQ-028 mem_rdata SHALL be ignored outside WAIT.
REQ-029 branch_taken and halt_req SHALL be ignored outside EXECUTE.
REQ-030 All outputs SHALL be registered or decoded from registered state only; there SHALL be no latches and no combinational path from input to output.

Reset
REQ-031 reset=0 SHALL asynchronously force state FETCH, PC_out=RESET_PC, instruction_out=0, instr_valid=0, and current_state=0.
REQ-032 mem_req SHALL be 1 during reset, as decoded from FETCH.
REQ-033 Reset asserted in any state, including mid-WAIT, SHALL abandon the pending read; a late mem_valid SHALL be ignored.
REQ-034 The first fetch after deassertion SHALL be at RESET_PC.

Structure
REQ-035 Shared package fseq_pkg SHALL hold the state encodings and the default IW/PW constants.
REQ-036 Sub-module fseq_pc (PC register with increment/load/hold and reset to RESET_PC) SHALL be instantiated once.
REQ-037 The top level SHALL contain the FSM and the instruction register.

Verification
REQ-038 Reset, then mem_valid=1 every WAIT and instructions 0xA0000000+n -> PC_out sequence 0,1,2,3 with 4 cycles per step; instruction_out=0xA0000000+n during DECODE/EXECUTE of step n.
REQ-039 mem_valid delayed 3 cycles -> WAIT held 3 cycles, mem_req high throughout, PC_out unchanged.
REQ-040 stall=1 for 2 cycles in DECODE and 1 in EXECUTE -> no PC change while stalled; instr_valid high 2 cycles total.
REQ-041 branch_taken=1, branch_target=0x1234 in EXECUTE -> next FETCH at PC_out=0x1234; PW=16 with PC_out=0xFFFF and no branch -> next PC_out=0x0000.
REQ-042 halt_req=1 in EXECUTE -> HALT with PC advanced; resume pulse after 5 cycles -> FETCH on the next edge.
REQ-043 reset pulsed mid-WAIT, then mem_valid=1 -> state FETCH, PC_out=RESET_PC, instruction_out=0, stale data not captured.
